mem_responder: RTL and testbench

Memory-side responder for the core's IM and DM ports. It holds two word arrays: instruction memory and data memory.
- IM: synchronous instruction fetch.
- DM: synchronous read and masked write, with active-low write enable and active-low per-bit write mask.
- Boot loader: a valid/ready stream fills either array before the core is released.
- Sits at top level between the CPU and the testbench/loader. The CPU's reset is driven from core_rst.

---
 rtl/mem_pkg.sv | 18 +
 rtl/sram_1p.sv | 55 +++++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   state_e     : responder phase (BOOT = loader owns the arrays, RUN = core owns them)
//   IM_SEL/DM_SEL : loader target select encodings
//   ADDR_W_DEF/DATA_W_DEF : default geometry of each array
package mem_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic IM_SEL = 1'b0;
  localparam logic DM_SEL = 1'b1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_1p.sv
// Single-port synchronous RAM with active-low write enable and active-low
// per-bit write mask.
//   clk, rst : clock and synchronous active-high reset (clears dout only)
//   ce       : port enable; when low the array and dout are untouched
//   web      : 0 = write, 1 = read
//   bweb     : per-bit write mask, 0 = write that bit
//   a        : word address
//   din      : write data
//   dout     : registered read data; holds its value on write and idle cycles
module sram_1p
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              web,
  input  logic [DATA_W-1:0] bweb,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  // Only a read cycle updates dout; no write-through.
  always_comb begin
    dout_d = dout_q;
    if (ce && web) begin
      dout_d = mem_q[a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  // Array contents have no reset. Mask bits at 1 keep the stored bit.
  always_ff @(posedge clk) begin
    if (ce && !web) begin
      mem_q[a] <= (mem_q[a] & bweb) | (din & ~bweb);
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core's instruction and data ports.
// A boot loader stream (ld_valid/ld_ready) fills IM or DM while the core is
// held in reset; after the ld_last handshake the core is released and owns
// both arrays until the next rst.
//   pc / instr                        : IM fetch, one-cycle latency, RUN only
//   DM_A/DM_WEB/DM_BWEB/DM_IN/DM_OUT  : DM read / masked write, RUN only
//   ld_valid/ld_ready/ld_sel/ld_addr/ld_data/ld_last : loader stream
//   core_rst                          : high until boot completes
//   ld_count                          : loader words accepted, saturating
// Handshake: a loader word transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_valid may be held or dropped freely, ld_ready
// is high for the whole BOOT phase and low in RUN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit SKIP_BOOT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] DM_A,
  input  logic              DM_WEB,
  input  logic [DATA_W-1:0] DM_BWEB,
  input  logic [DATA_W-1:0] DM_IN,
  output logic [DATA_W-1:0] DM_OUT,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              core_rst,
  output logic [ADDR_W:0]   ld_count
);

  localparam state_e        RST_STATE = SKIP_BOOT ? RUN : BOOT;
  localparam logic [ADDR_W:0] LD_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              ld_ready_q;
  logic              core_rst_q;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              hs;

  logic              im_ce, im_web;
  logic [ADDR_W-1:0] im_a;
  logic              dm_ce, dm_web;
  logic [DATA_W-1:0] dm_bweb, dm_din;
  logic [ADDR_W-1:0] dm_a;

  // ld_ready_q is high exactly when state_q is BOOT.
  assign hs = ld_valid && ld_ready_q;

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    if (hs) begin
      if (ld_count_q != LD_MAX) begin
        ld_count_d = ld_count_q + 1'b1;
      end
      if (ld_last) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      ld_ready_q <= (RST_STATE == BOOT);
      core_rst_q <= (RST_STATE == BOOT);
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_d == BOOT);
      core_rst_q <= (state_d == BOOT);
      ld_count_q <= ld_count_d;
    end
  end

  // Port steering: core in RUN, loader in BOOT. Nothing reaches the arrays
  // in an rst cycle, so a coinciding handshake is dropped.
  always_comb begin
    im_ce   = 1'b0;
    im_web  = 1'b1;
    im_a    = pc;
    dm_ce   = 1'b0;
    dm_web  = 1'b1;
    dm_bweb = '1;
    dm_a    = DM_A;
    dm_din  = DM_IN;
    if (!rst) begin
      if (state_q == RUN) begin
        im_ce   = 1'b1;
        dm_ce   = 1'b1;
        dm_web  = DM_WEB;
        dm_bweb = DM_BWEB;
      end else if (hs) begin
        if (ld_sel == IM_SEL) begin
          im_ce  = 1'b1;
          im_web = 1'b0;
          im_a   = ld_addr;
        end else begin
          dm_ce   = 1'b1;
          dm_web  = 1'b0;
          dm_bweb = '0;
          dm_a    = ld_addr;
          dm_din  = ld_data;
        end
      end
    end
  end

  sram_1p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_im (
    .clk  (clk),
    .rst  (rst),
    .ce   (im_ce),
    .web  (im_web),
    .bweb ({DATA_W{1'b0}}),
    .a    (im_a),
    .din  (ld_data),
    .dout (instr)
  );

  sram_1p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dm (
    .clk  (clk),
    .rst  (rst),
    .ce   (dm_ce),
    .web  (dm_web),
    .bweb (dm_bweb),
    .a    (dm_a),
    .din  (dm_din),
    .dout (DM_OUT)
  );

  assign ld_ready = ld_ready_q;
  assign core_rst = core_rst_q;
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic [AW-1:0] dm_a;
  logic          dm_web;
  logic [DW-1:0] dm_bweb;
  logic [DW-1:0] dm_in;
  logic [DW-1:0] dm_out;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          core_rst;
  logic [AW:0]   ld_count;

  // SKIP_BOOT=1 instance
  logic [AW-1:0] pc_s;
  logic [DW-1:0] instr_s;
  logic [AW-1:0] dm_a_s;
  logic          dm_web_s;
  logic [DW-1:0] dm_bweb_s;
  logic [DW-1:0] dm_in_s;
  logic [DW-1:0] dm_out_s;
  logic          ld_valid_s;
  logic          ld_ready_s;
  logic          ld_sel_s;
  logic [AW-1:0] ld_addr_s;
  logic [DW-1:0] ld_data_s;
  logic          ld_last_s;
  logic          core_rst_s;
  logic [AW:0]   ld_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];     // expected instr values
  logic [DW-1:0] dm_exp_q[$];  // expected DM_OUT values

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .SKIP_BOOT(1'b0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr),
    .DM_A(dm_a), .DM_WEB(dm_web), .DM_BWEB(dm_bweb), .DM_IN(dm_in), .DM_OUT(dm_out),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .core_rst(core_rst), .ld_count(ld_count)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .SKIP_BOOT(1'b1)) dut_skip (
    .clk(clk), .rst(rst), .pc(pc_s), .instr(instr_s),
    .DM_A(dm_a_s), .DM_WEB(dm_web_s), .DM_BWEB(dm_bweb_s), .DM_IN(dm_in_s), .DM_OUT(dm_out_s),
    .ld_valid(ld_valid_s), .ld_ready(ld_ready_s), .ld_sel(ld_sel_s), .ld_addr(ld_addr_s),
    .ld_data(ld_data_s), .ld_last(ld_last_s), .core_rst(core_rst_s), .ld_count(ld_count_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic load_word(input logic sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic last);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Drive pc, queue the expected word, then compare after the edge.
  task automatic fetch(input logic [AW-1:0] addr, input logic [DW-1:0] expv);
    logic [DW-1:0] e;
    pc = addr;
    exp_q.push_back(expv);
    tick();
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL fetch_queue: instr=%h but no expected value queued", instr);
    end else begin
      e = exp_q.pop_front();
      if (instr !== e) $display("FAIL fetch pc=%0d: got %h expected %h", addr, instr, e);
      else n_pass++;
    end
  endtask

  task automatic dm_read(input logic [AW-1:0] addr, input logic [DW-1:0] expv);
    logic [DW-1:0] e;
    dm_a   = addr;
    dm_web = 1'b1;
    dm_exp_q.push_back(expv);
    tick();
    n_checks++;
    if (dm_exp_q.size() == 0) begin
      $display("FAIL dm_queue: DM_OUT=%h but no expected value queued", dm_out);
    end else begin
      e = dm_exp_q.pop_front();
      if (dm_out !== e) $display("FAIL dm_read a=%0d: got %h expected %h", addr, dm_out, e);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr); else n_pass++;
    n_checks++; if (dm_out !== 32'h0) $display("FAIL reset_dm_out: got %h expected 0", dm_out); else n_pass++;
    n_checks++; if (ld_count !== 15'd0) $display("FAIL reset_ld_count: got %0d expected 0", ld_count); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); else n_pass++;
    n_checks++; if (core_rst !== 1'b1) $display("FAIL reset_core_rst: got %b expected 1", core_rst); else n_pass++;
    n_checks++; if (core_rst_s !== 1'b0) $display("FAIL skip_reset_core_rst: got %b expected 0", core_rst_s); else n_pass++;
    n_checks++; if (ld_ready_s !== 1'b0) $display("FAIL skip_reset_ld_ready: got %b expected 0", ld_ready_s); else n_pass++;
    n_checks++; if (ld_count_s !== 15'd0) $display("FAIL skip_reset_ld_count: got %0d expected 0", ld_count_s); else n_pass++;
    rst = 1'b0;
  endtask

  // Push 2**AW + 1 words without ld_last; the count must stop at 2**AW.
  task automatic test_count_saturation();
    logic [AW:0] sat;
    sat = 15'd1 << AW;
    for (int i = 0; i <= (1 << AW); i++) begin
      load_word(1'b1, i[AW-1:0], i[DW-1:0], 1'b0);
      if (i == (1 << AW) - 1) begin
        n_checks++;
        if (ld_count !== sat) $display("FAIL count_at_max: got %0d expected %0d", ld_count, sat);
        else n_pass++;
      end
    end
    n_checks++; if (ld_count !== sat) $display("FAIL count_saturate: got %0d expected %0d", ld_count, sat); else n_pass++;
    n_checks++; if (core_rst !== 1'b1) $display("FAIL count_core_rst: got %b expected 1", core_rst); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (ld_count !== 15'd0) $display("FAIL count_after_rst: got %0d expected 0", ld_count); else n_pass++;
  endtask

  task automatic test_mid_load_reset();
    load_word(1'b0, 14'd2, 32'h1111_1111, 1'b0);
    load_word(1'b1, 14'd3, 32'h2222_2222, 1'b0);
    n_checks++; if (ld_count !== 15'd2) $display("FAIL midload_count: got %0d expected 2", ld_count); else n_pass++;
    // Handshake coinciding with rst must be dropped.
    rst = 1'b1;
    load_word(1'b1, 14'd3, 32'h3333_3333, 1'b0);
    rst = 1'b0;
    n_checks++; if (ld_count !== 15'd0) $display("FAIL midload_rst_count: got %0d expected 0", ld_count); else n_pass++;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL midload_rst_ready: got %b expected 1", ld_ready); else n_pass++;
    n_checks++; if (core_rst !== 1'b1) $display("FAIL midload_rst_core_rst: got %b expected 1", core_rst); else n_pass++;
  endtask

  task automatic test_backpressure();
    // Core tries to write DM[3] during BOOT; loader stays idle.
    dm_a    = 14'd3;
    dm_web  = 1'b0;
    dm_bweb = 32'h0;
    dm_in   = 32'hA5A5_A5A5;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_addr  = 14'd0;
    ld_data  = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (ld_count !== 15'd0) $display("FAIL idle_count c=%0d: got %0d expected 0", c, ld_count); else n_pass++;
      n_checks++; if (core_rst !== 1'b1) $display("FAIL idle_core_rst c=%0d: got %b expected 1", c, core_rst); else n_pass++;
      n_checks++; if (dm_out !== 32'h0) $display("FAIL idle_dm_out c=%0d: got %h expected 0", c, dm_out); else n_pass++;
      n_checks++; if (instr !== 32'h0) $display("FAIL idle_instr c=%0d: got %h expected 0", c, instr); else n_pass++;
    end
    dm_web = 1'b1;
  endtask

  task automatic test_boot_load();
    load_word(1'b0, 14'd0, 32'h0000_0013, 1'b0);
    n_checks++; if (core_rst !== 1'b1) $display("FAIL boot_core_rst_mid: got %b expected 1", core_rst); else n_pass++;
    load_word(1'b0, 14'd1, 32'h0010_0093, 1'b0);
    load_word(1'b1, 14'd5, 32'hDEAD_BEEF, 1'b1);
    n_checks++; if (ld_count !== 15'd3) $display("FAIL boot_count: got %0d expected 3", ld_count); else n_pass++;
    n_checks++; if (core_rst !== 1'b0) $display("FAIL boot_core_rst_fall: got %b expected 0", core_rst); else n_pass++;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL boot_ld_ready_run: got %b expected 0", ld_ready); else n_pass++;
  endtask

  task automatic test_fetch();
    fetch(14'd1, 32'h0010_0093);
    fetch(14'd0, 32'h0000_0013);
    fetch(14'd2, 32'h1111_1111);  // written before the mid-load reset
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] im_model [3];
    int k;
    im_model[0] = 32'h0000_0013;
    im_model[1] = 32'h0010_0093;
    im_model[2] = 32'h1111_1111;
    for (int c = 0; c < 8; c++) begin
      k = $urandom_range(0, 2);
      fetch(k[AW-1:0], im_model[k]);
    end
  endtask

  task automatic test_dm_boot_preserved();
    // Neither the rst-cycle handshake nor the BOOT core write touched DM[3].
    dm_read(14'd3, 32'h2222_2222);
  endtask

  task automatic test_masked_write();
    dm_read(14'd5, 32'hDEAD_BEEF);
    dm_web  = 1'b0;
    dm_a    = 14'd5;
    dm_in   = 32'h1122_3344;
    dm_bweb = 32'hFFFF_00FF;
    tick();
    dm_web = 1'b1;
    n_checks++; if (dm_out !== 32'hDEAD_BEEF) $display("FAIL write_hold: got %h expected deadbeef", dm_out); else n_pass++;
    dm_read(14'd5, 32'hDEAD_33EF);
  endtask

  task automatic test_loader_ignored_in_run();
    load_word(1'b1, 14'd5, 32'h0, 1'b1);
    n_checks++; if (ld_count !== 15'd3) $display("FAIL run_ld_count: got %0d expected 3", ld_count); else n_pass++;
    n_checks++; if (core_rst !== 1'b0) $display("FAIL run_core_rst: got %b expected 0", core_rst); else n_pass++;
    dm_read(14'd5, 32'hDEAD_33EF);
  endtask

  task automatic test_skip_boot();
    for (int c = 0; c < 3; c++) begin
      ld_valid_s = 1'b1;
      ld_last_s  = 1'b1;
      ld_sel_s   = c[0];
      ld_addr_s  = c[AW-1:0];
      ld_data_s  = $urandom;
      tick();
      ld_valid_s = 1'b0;
      n_checks++; if (ld_count_s !== 15'd0) $display("FAIL skip_count c=%0d: got %0d expected 0", c, ld_count_s); else n_pass++;
      n_checks++; if (core_rst_s !== 1'b0) $display("FAIL skip_core_rst c=%0d: got %b expected 0", c, core_rst_s); else n_pass++;
      n_checks++; if (ld_ready_s !== 1'b0) $display("FAIL skip_ld_ready c=%0d: got %b expected 0", c, ld_ready_s); else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    pc = '0; dm_a = '0; dm_web = 1'b1; dm_bweb = '1; dm_in = '0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    pc_s = '0; dm_a_s = '0; dm_web_s = 1'b1; dm_bweb_s = '1; dm_in_s = '0;
    ld_valid_s = 1'b0; ld_sel_s = 1'b0; ld_addr_s = '0; ld_data_s = '0; ld_last_s = 1'b0;

    test_reset();
    test_count_saturation();
    test_mid_load_reset();
    test_backpressure();
    test_boot_load();
    test_fetch();
    test_back_to_back();
    test_dm_boot_preserved();
    test_masked_write();
    test_loader_ignored_in_run();
    test_skip_boot();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
